// File: rtl/tank_select_sequencer.sv
// Registered tank select sequencer: accepts a handshaked transfer request, drives one
// one-hot in/out select for HOLD_TICKS pulse intervals, then pulses done.
module tank_select_sequencer #(
  parameter  int NUM_TANKS   = 32,
  parameter  int TANK_ADDR_W = 5,
  parameter  int HOLD_TICKS  = 18,
  localparam int CNT_W       = $clog2(HOLD_TICKS + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req,
  input  logic                   dir_in,
  input  logic [TANK_ADDR_W-1:0] tank_addr,
  input  logic                   pulse_en,
  input  logic                   abort,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic [NUM_TANKS-1:0]   tank_in,
  output logic [NUM_TANKS-1:0]   tank_out
);

  localparam logic [CNT_W-1:0]     LAST_TICK = CNT_W'(HOLD_TICKS - 1);
  localparam logic [TANK_ADDR_W:0] TANK_LIM  = (TANK_ADDR_W + 1)'(NUM_TANKS);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_DONE   = 2'd2
  } state_e;

  state_e               state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 err_q;
  logic [NUM_TANKS-1:0] tank_in_q;
  logic [NUM_TANKS-1:0] tank_out_q;

  logic [NUM_TANKS-1:0] sel_d;
  logic                 addr_ok_d;

  // Extra top bit lets NUM_TANKS == 2**TANK_ADDR_W compare without overflow.
  assign addr_ok_d = ({1'b0, tank_addr} < TANK_LIM);

  for (genvar gi = 0; gi < NUM_TANKS; gi++) begin : g_decode
    assign sel_d[gi] = (tank_addr == TANK_ADDR_W'(gi));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      tank_in_q  <= '0;
      tank_out_q <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req) begin
            if (addr_ok_d) begin
              state_q    <= S_ACTIVE;
              cnt_q      <= '0;
              busy_q     <= 1'b1;
              tank_in_q  <= dir_in ? sel_d : '0;
              tank_out_q <= dir_in ? '0 : sel_d;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        S_ACTIVE: begin
          // Abort takes priority over a coinciding final tick, so no done is emitted.
          if (abort) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            tank_in_q  <= '0;
            tank_out_q <= '0;
          end else if (pulse_en) begin
            if (cnt_q == LAST_TICK) begin
              state_q    <= S_DONE;
              cnt_q      <= '0;
              done_q     <= 1'b1;
              tank_in_q  <= '0;
              tank_out_q <= '0;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q    <= S_IDLE;
          cnt_q      <= '0;
          busy_q     <= 1'b0;
          tank_in_q  <= '0;
          tank_out_q <= '0;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  assign tank_in  = tank_in_q;
  assign tank_out = tank_out_q;

endmodule
